// File: rtl/zilla_div_defs.sv
// Shared definitions for the Zilla 64/32 sequential divider: FSM encoding,
// default widths and saturation constants.
package zilla_div_defs;

  localparam int DW_DEF = 32;
  localparam int CW_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ITER  = 2'd2,
    DONE  = 2'd3
  } div_state_e;

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] SAT_POS  = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG  = 32'h8000_0000;

endpackage

// File: rtl/div_restore_step.sv
// One combinational radix-2 restoring division step on a guarded partial
// remainder; the caller guarantees r < divisor on entry.
module div_restore_step #(
  parameter int DW = 32
) (
  input  logic [DW:0]   r,
  input  logic [DW-1:0] q,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   r_next,
  output logic [DW-1:0] q_next
);

  logic [DW+1:0] shifted;
  logic [DW+1:0] trial;

  // Shift is taken one bit wider than the remainder so the sign of the trial
  // subtraction lands in a dedicated bit.
  assign shifted = {r, q[DW-1]};
  assign trial   = shifted - {2'b00, divisor};

  always_comb begin
    r_next = shifted[DW:0];
    q_next = {q[DW-2:0], 1'b0};
    if (!trial[DW+1]) begin
      r_next = trial[DW:0];
      q_next = {q[DW-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_div_64by32.sv
// Iterative 64/32 restoring divider with valid/ready handshakes.
// Define ZILLA_DIV_SIGNED_EN for two's-complement operands.
module seq_div_64by32
  import zilla_div_defs::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_by_zero,
  output logic            overflow
);

  div_state_e state, state_nxt;

  logic [CW-1:0]   cnt;
  logic [2*DW-1:0] dvd_raw;
  logic [DW-1:0]   dvs_raw;
  logic [DW:0]     r_reg;
  logic [DW-1:0]   q_reg;
  logic [DW-1:0]   dvs_mag;
  logic [DW:0]     r_step;
  logic [DW-1:0]   q_step;
  logic [2*DW-1:0] dvd_in_mag;
  logic [DW-1:0]   dvs_in_mag;
  logic [DW-1:0]   sat_q;
  logic [DW-1:0]   final_q;
  logic [DW-1:0]   final_r;
  logic            final_ovf;
  logic            is_zero;
  logic            is_ovf;
  logic            last_step;

`ifdef ZILLA_DIV_SIGNED_EN
  logic sign_q, sign_r, sign_q_in, mag_ovf;

  assign sign_q_in  = dvd_raw[2*DW-1] ^ dvs_raw[DW-1];
  assign dvd_in_mag = dvd_raw[2*DW-1] ? -dvd_raw : dvd_raw;
  assign dvs_in_mag = dvs_raw[DW-1] ? -dvs_raw : dvs_raw;
  assign sat_q      = sign_q_in ? SAT_NEG : SAT_POS;

  // A negative quotient may reach 2^31 in magnitude, a positive one only 2^31-1.
  always_comb begin
    mag_ovf   = sign_q ? (q_step > SAT_NEG) : (q_step > SAT_POS);
    final_ovf = 1'b0;
    final_q   = sign_q ? -q_step : q_step;
    final_r   = sign_r ? -r_step[DW-1:0] : r_step[DW-1:0];
    if (mag_ovf) begin
      final_ovf = 1'b1;
      final_q   = sign_q ? SAT_NEG : SAT_POS;
      final_r   = dvd_raw[DW-1:0];
    end
  end
`else
  assign dvd_in_mag = dvd_raw;
  assign dvs_in_mag = dvs_raw;
  assign sat_q      = ALL_ONES;
  assign final_q    = q_step;
  assign final_r    = r_step[DW-1:0];
  assign final_ovf  = 1'b0;
`endif

  assign is_zero   = (dvs_raw == '0);
  assign is_ovf    = (dvd_in_mag[2*DW-1:DW] >= dvs_in_mag);
  assign last_step = (cnt == CW'(DW-1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  div_restore_step #(.DW(DW)) u_step (
    .r       (r_reg),
    .q       (q_reg),
    .divisor (dvs_mag),
    .r_next  (r_step),
    .q_next  (q_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CHECK;
      CHECK:   state_nxt = (is_zero || is_ovf) ? DONE : ITER;
      ITER:    if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operands are only ever sampled on the IDLE handshake, and the
  // result registers only change on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      dvd_raw     <= '0;
      dvs_raw     <= '0;
      r_reg       <= '0;
      q_reg       <= '0;
      dvs_mag     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
`ifdef ZILLA_DIV_SIGNED_EN
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_raw     <= dividend;
            dvs_raw     <= divisor;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        CHECK: begin
          if (is_zero) begin
            quotient    <= ALL_ONES;
            remainder   <= dvd_raw[DW-1:0];
            div_by_zero <= 1'b1;
          end else if (is_ovf) begin
            quotient  <= sat_q;
            remainder <= dvd_raw[DW-1:0];
            overflow  <= 1'b1;
          end else begin
            r_reg   <= {1'b0, dvd_in_mag[2*DW-1:DW]};
            q_reg   <= dvd_in_mag[DW-1:0];
            dvs_mag <= dvs_in_mag;
            cnt     <= '0;
`ifdef ZILLA_DIV_SIGNED_EN
            sign_q  <= sign_q_in;
            sign_r  <= dvd_raw[2*DW-1];
`endif
          end
        end
        ITER: begin
          r_reg <= r_step;
          q_reg <= q_step;
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            quotient  <= final_q;
            remainder <= final_r;
            overflow  <= final_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_64by32.sv
// Self-checking bench for seq_div_64by32 (unsigned build): directed cases plus
// randomized operands checked against plain 64-bit arithmetic.
module tb_seq_div_64by32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  seq_div_64by32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain division, flags decided from the operand values alone.
  task automatic model(input logic [63:0] dvd, input logic [31:0] dvs,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic dbz, output logic ovf, output int lat);
    logic [63:0] qq, rr;
    dbz = 1'b0; ovf = 1'b0; lat = 33;
    if (dvs == 32'd0) begin
      dbz = 1'b1; q = 32'hFFFF_FFFF; r = dvd[31:0]; lat = 1;
    end else if ((dvd / {32'd0, dvs}) > 64'h0000_0000_FFFF_FFFF) begin
      ovf = 1'b1; q = 32'hFFFF_FFFF; r = dvd[31:0]; lat = 1;
    end else begin
      qq = dvd / {32'd0, dvs};
      rr = dvd % {32'd0, dvs};
      q  = qq[31:0];
      r  = rr[31:0];
    end
  endtask

  // Issues one operation and waits (bounded) for the result; does not accept it.
  task automatic issue(input logic [63:0] dvd, input logic [31:0] dvs,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic edbz, input logic eovf, input int elat,
                       input string tag);
    int lat;
    @(negedge clk);
    check({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 100);
    check({tag, ".latency"}, 64'(lat), 64'(elat));
    check({tag, ".quotient"}, {32'd0, quotient}, {32'd0, eq});
    check({tag, ".remainder"}, {32'd0, remainder}, {32'd0, er});
    check({tag, ".div_by_zero"}, {63'd0, div_by_zero}, {63'd0, edbz});
    check({tag, ".overflow"}, {63'd0, overflow}, {63'd0, eovf});
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".out_valid_drop"}, {63'd0, out_valid}, 64'd0);
    check({tag, ".in_ready_rise"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [31:0] mq, mr, rdvs;
    logic [63:0] rdvd;
    logic        mdbz, movf;
    int          mlat;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready", {63'd0, in_ready}, 64'd1);
    check("reset.out_valid", {63'd0, out_valid}, 64'd0);
    check("reset.quotient", {32'd0, quotient}, 64'd0);
    check("reset.remainder", {32'd0, remainder}, 64'd0);
    check("reset.flags", {62'd0, div_by_zero, overflow}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33, "d100_7");
    accept("d100_7");

    issue(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 33, "prod");
    accept("prod");

    issue(64'h1234_5678_9ABC_DEF0, 32'd0, 32'hFFFF_FFFF, 32'h9ABC_DEF0, 1'b1, 1'b0, 1, "dbz");
    accept("dbz");

    issue(64'h1_0000_0000, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1, "ovf");
    accept("ovf");
    issue(64'd5, 32'd2, 32'd2, 32'd1, 1'b0, 1'b0, 33, "d5_2");
    accept("d5_2");

    // Result held with out_ready low while other operands are offered.
    issue(64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33, "hold");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 64'd5;
      divisor  = 32'd1;
      check("hold.out_valid", {63'd0, out_valid}, 64'd1);
      check("hold.in_ready", {63'd0, in_ready}, 64'd0);
      check("hold.result", {quotient, remainder}, {32'd14, 32'd2});
    end
    @(negedge clk);
    in_valid = 1'b0;
    accept("hold");
    issue(64'd9, 32'd4, 32'd2, 32'd1, 1'b0, 1'b0, 33, "after_hold");
    accept("after_hold");

    // Reset in the middle of the iteration loop.
    @(negedge clk);
    dividend = 64'd100;
    divisor  = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst.outputs", {quotient, remainder}, 64'd0);
    check("midrst.in_ready", {63'd0, in_ready}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("midrst.still_idle", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33, "post_rst");
    accept("post_rst");

    for (int i = 0; i < 24; i++) begin
      int sel;
      sel  = $urandom_range(0, 7);
      rdvd = {$urandom, $urandom};
      rdvs = $urandom;
      if (sel == 0) rdvs = 32'd0;
      else if (sel == 1) rdvs = $urandom_range(1, 255);
      else begin
        if (rdvs == 32'd0) rdvs = 32'd3;
        if (rdvd[63:32] >= rdvs) rdvd[63:32] = rdvd[63:32] % rdvs;
      end
      model(rdvd, rdvs, mq, mr, mdbz, movf, mlat);
      issue(rdvd, rdvs, mq, mr, mdbz, movf, mlat, $sformatf("rand%0d", i));
      accept($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
